// File: rtl/chan_ctrl_gen_if.sv
`default_nettype none
// chan_ctrl_gen_if: state-RAM port and fetch/mix FIFO byte stream of the channel controller.
// Revision 1.0
interface chan_ctrl_gen_if #(
  parameter int CH_W = 5
);
  logic [CH_W+1:0] rd_addr;
  logic [31:0]     rd_data;
  logic [CH_W+1:0] wr_addr;
  logic [31:0]     wr_data;
  logic            wr_stb;
  logic [7:0]      out_data;
  logic            out_stb_addr;
  logic            out_stb_mix;
  logic            out_rdy;

  modport master (
    output rd_addr, wr_addr, wr_data, wr_stb, out_data, out_stb_addr, out_stb_mix,
    input  rd_data, out_rdy
  );

  modport slave (
    input  rd_addr, wr_addr, wr_data, wr_stb, out_data, out_stb_addr, out_stb_mix,
    output rd_data, out_rdy
  );
endinterface
`default_nettype wire

// File: rtl/chan_ctrl_gen.sv
`default_nettype none
// chan_ctrl_gen: once per frame walks NUM_CH channel records, advances offsets, streams 6 bytes/channel.
// Revision 1.0
module chan_ctrl_gen #(
  parameter  int NUM_CH = 32,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  wire               clk_i,
  input  wire               rst_ni,
  input  wire               ena_i,
  input  wire               sync_stb_i,
  input  wire  [NUM_CH-1:0] ch_enas_i,
  input  wire               ovr_clr_i,
  output logic              ch_done_o,
  output logic [CH_W-1:0]   ch_done_num_o,
  output logic              busy_o,
  output logic              overrun_o,
  chan_ctrl_gen_if.master   bus
);
  localparam int CNT_W = CH_W + 1;

  typedef enum logic [3:0] {
    S_WAIT, S_BEGIN, S_G0, S_G1, S_G2, S_G3, S_SAVE, S_EMIT, S_NEXT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  ch_q, ch_d;
  logic [2:0]        beat_q, beat_d;
  logic [31:0]       offset_q, offset_d;
  logic [32:0]       sum_q, sum_d;
  logic              loopena_q, loopena_d, surr_q, surr_d;
  logic [5:0]        vl_q, vl_d, vr_q, vr_d;
  logic [19:0]       size_q, size_d;
  logic [13:0]       base_q, base_d;
  logic              pre_q, pre_d, over_q, over_d, mute_q, mute_d;
  logic [21:0]       addr_q, addr_d;
  logic [CH_W+1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic              wr_stb_q, wr_stb_d, stb_addr_q, stb_addr_d, stb_mix_q, stb_mix_d;
  logic [7:0]        out_data_q, out_data_d;
  logic              done_q, done_d, busy_q, overrun_q, overrun_d;
  logic [CH_W-1:0]   done_num_q, done_num_d;

  logic [(1<<CH_W)-1:0] w_enas;
  logic [CH_W-1:0]      w_ch, w_ch_inc;
  logic [CNT_W-1:0]     w_ch_nxt;
  logic [19:0]          w_looplen;
  logic [7:0]           w_byte;

  assign w_ch      = ch_q[CH_W-1:0];
  assign w_ch_nxt  = ch_q + CNT_W'(1);
  assign w_ch_inc  = w_ch_nxt[CH_W-1:0];
  assign w_looplen = bus.rd_data[27:8];

  always_comb begin
    w_enas = '0;
    w_enas[NUM_CH-1:0] = ch_enas_i;
  end

  // Idle and one-shot-finished channels still stream their bytes, but with zero volume.
  always_comb begin
    case (beat_q)
      3'd0:    w_byte = {2'b00, addr_q[21:16]};
      3'd1:    w_byte = addr_q[15:8];
      3'd2:    w_byte = addr_q[7:0];
      3'd3:    w_byte = wr_data_q[11:4];
      3'd4:    w_byte = {2'b00, mute_q ? 6'd0 : vl_q};
      default: w_byte = {2'b00, mute_q ? 6'd0 : (vr_q ^ {6{surr_q}})};
    endcase
  end

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    beat_d     = beat_q;
    offset_d   = offset_q;
    sum_d      = sum_q;
    loopena_d  = loopena_q;
    surr_d     = surr_q;
    vl_d       = vl_q;
    vr_d       = vr_q;
    size_d     = size_q;
    base_d     = base_q;
    pre_d      = pre_q;
    over_d     = over_q;
    mute_d     = mute_q;
    addr_d     = addr_q;
    rd_addr_d  = rd_addr_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_stb_d   = 1'b0;
    out_data_d = out_data_q;
    stb_addr_d = 1'b0;
    stb_mix_d  = 1'b0;
    done_d     = 1'b0;
    done_num_d = done_num_q;
    overrun_d  = ovr_clr_i ? 1'b0 : (overrun_q | (sync_stb_i && (state_q != S_WAIT)));

    // rd_addr is loaded on entry to a state so the RAM word lands in the following state.
    case (state_q)
      S_WAIT: begin
        if (sync_stb_i && ena_i) begin
          state_d   = S_BEGIN;
          ch_d      = '0;
          rd_addr_d = '0;
        end
      end
      S_BEGIN: begin
        if ((ch_q == CNT_W'(NUM_CH)) || !ena_i) begin
          state_d = S_WAIT;
        end else if (!w_enas[w_ch]) begin
          state_d = S_NEXT;
        end else begin
          state_d   = S_G0;
          rd_addr_d = {w_ch, 2'd1};
        end
      end
      S_G0: begin
        offset_d  = bus.rd_data;
        rd_addr_d = {w_ch, 2'd2};
        state_d   = S_G1;
      end
      S_G1: begin
        sum_d     = {1'b0, offset_q} + {15'd0, bus.rd_data[31:14]};
        loopena_d = bus.rd_data[13];
        surr_d    = bus.rd_data[12];
        vl_d      = bus.rd_data[11:6];
        vr_d      = bus.rd_data[5:0];
        rd_addr_d = {w_ch, 2'd3};
        state_d   = S_G2;
      end
      S_G2: begin
        size_d  = bus.rd_data[27:8];
        base_d  = {base_q[13:8], bus.rd_data[7:0]};
        pre_d   = offset_q[31:12] >= bus.rd_data[27:8];
        over_d  = sum_q[32:12] >= {1'b0, bus.rd_data[27:8]};
        state_d = S_G3;
      end
      S_G3: begin
        base_d    = {bus.rd_data[5:0], base_q[7:0]};
        mute_d    = 1'b0;
        if (pre_q && !loopena_q) begin
          wr_data_d = offset_q;
          mute_d    = 1'b1;
        end else if (over_q && loopena_q) begin
          wr_data_d = {sum_q[31:12] - w_looplen, sum_q[11:0]};
        end else if (over_q) begin
          wr_data_d  = {size_q, 12'd0};
          mute_d     = 1'b1;
          done_d     = 1'b1;
          done_num_d = w_ch;
        end else begin
          wr_data_d = sum_q[31:0];
        end
        wr_addr_d = {w_ch, 2'd0};
        wr_stb_d  = 1'b1;
        state_d   = S_SAVE;
      end
      S_SAVE: begin
        addr_d  = {base_q, 8'd0} + {2'b00, wr_data_q[31:12]};
        beat_d  = 3'd0;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (bus.out_rdy) begin
          out_data_d = w_byte;
          stb_addr_d = (beat_q < 3'd3);
          stb_mix_d  = (beat_q >= 3'd3);
          if (beat_q == 3'd5) state_d = S_NEXT;
          else                beat_d  = beat_q + 3'd1;
        end
      end
      S_NEXT: begin
        ch_d      = w_ch_nxt;
        rd_addr_d = {w_ch_inc, 2'd0};
        state_d   = S_BEGIN;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_WAIT;
      ch_q       <= '0;
      beat_q     <= '0;
      offset_q   <= '0;
      sum_q      <= '0;
      loopena_q  <= 1'b0;
      surr_q     <= 1'b0;
      vl_q       <= '0;
      vr_q       <= '0;
      size_q     <= '0;
      base_q     <= '0;
      pre_q      <= 1'b0;
      over_q     <= 1'b0;
      mute_q     <= 1'b0;
      addr_q     <= '0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_stb_q   <= 1'b0;
      out_data_q <= '0;
      stb_addr_q <= 1'b0;
      stb_mix_q  <= 1'b0;
      done_q     <= 1'b0;
      done_num_q <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      beat_q     <= beat_d;
      offset_q   <= offset_d;
      sum_q      <= sum_d;
      loopena_q  <= loopena_d;
      surr_q     <= surr_d;
      vl_q       <= vl_d;
      vr_q       <= vr_d;
      size_q     <= size_d;
      base_q     <= base_d;
      pre_q      <= pre_d;
      over_q     <= over_d;
      mute_q     <= mute_d;
      addr_q     <= addr_d;
      rd_addr_q  <= rd_addr_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_stb_q   <= wr_stb_d;
      out_data_q <= out_data_d;
      stb_addr_q <= stb_addr_d;
      stb_mix_q  <= stb_mix_d;
      done_q     <= done_d;
      done_num_q <= done_num_d;
      busy_q     <= (state_d != S_WAIT);
      overrun_q  <= overrun_d;
    end
  end

  assign bus.rd_addr      = rd_addr_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.wr_stb       = wr_stb_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_stb_addr = stb_addr_q;
  assign bus.out_stb_mix  = stb_mix_q;
  assign ch_done_o        = done_q;
  assign ch_done_num_o    = done_num_q;
  assign busy_o           = busy_q;
  assign overrun_o        = overrun_q;
endmodule
`default_nettype wire

// File: tb/tb_chan_ctrl_gen.sv
`default_nettype none
// tb_chan_ctrl_gen: scoreboard bench for a 4-channel chan_ctrl_gen with a behavioural channel model.
// Revision 1.0
module tb_chan_ctrl_gen;
  localparam int NCH = 4;
  localparam int CW  = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           ena = 1'b0;
  logic           sync = 1'b0;
  logic           ovr_clr = 1'b0;
  logic [NCH-1:0] enas = '0;
  logic           ch_done;
  logic [CW-1:0]  ch_done_num;
  logic           busy;
  logic           overrun;

  chan_ctrl_gen_if #(.CH_W(CW)) bus();

  chan_ctrl_gen #(.NUM_CH(NCH)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .ena_i        (ena),
    .sync_stb_i   (sync),
    .ch_enas_i    (enas),
    .ovr_clr_i    (ovr_clr),
    .ch_done_o    (ch_done),
    .ch_done_num_o(ch_done_num),
    .busy_o       (busy),
    .overrun_o    (overrun),
    .bus          (bus)
  );

  always #21 clk = ~clk;

  logic [31:0] ram  [16];
  logic [31:0] mram [16];

  always @(posedge clk) begin
    if (bus.wr_stb) ram[bus.wr_addr] <= bus.wr_data;
    bus.rd_data <= ram[bus.rd_addr];
  end

  int compared = 0;
  int mismatched = 0;
  logic [35:0] exp_wr[$];
  logic [8:0]  exp_byte[$];
  int          exp_done[$];
  bit          frame_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    compared++;
    mismatched++;
    $display("FAIL %s: got 0x%0h with nothing expected", name, act);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write, byte or done strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.wr_stb) begin
        if (exp_wr.size() == 0) unexpected("wr_unexpected", {bus.wr_addr, bus.wr_data});
        else check("wr", {bus.wr_addr, bus.wr_data}, exp_wr.pop_front());
      end
      if (bus.out_stb_addr || bus.out_stb_mix) begin
        if (exp_byte.size() == 0) unexpected("byte_unexpected", {bus.out_stb_addr, bus.out_data});
        else begin
          logic [8:0] e;
          e = exp_byte.pop_front();
          check("byte", {bus.out_stb_addr, bus.out_stb_mix, bus.out_data}, {e[8], ~e[8], e[7:0]});
        end
      end
      if (ch_done) begin
        if (exp_done.size() == 0) unexpected("done_unexpected", ch_done_num);
        else check("done_num", ch_done_num, exp_done.pop_front());
      end
    end
  end

  // Reference: one channel's frame update from the record-field rules, in plain arithmetic.
  task automatic model_ch(input int c);
    longint unsigned w0, w1, w2, w3, idx, size, step, sum, sidx, looplen, newoff, base, addr, vl, vr;
    bit loopena, surr, mute;
    logic [31:0] nw;
    logic [3:0]  wa;
    w0 = mram[c*4]; w1 = mram[c*4+1]; w2 = mram[c*4+2]; w3 = mram[c*4+3];
    idx     = w0 / 4096;
    step    = (w1 / 16384) % 262144;
    loopena = ((w1 / 8192) % 2) == 1;
    surr    = ((w1 / 4096) % 2) == 1;
    size    = (w2 / 256) % 1048576;
    looplen = (w3 / 256) % 1048576;
    base    = (w3 % 64) * 65536 + (w2 % 256) * 256;
    sum     = w0 + step;
    sidx    = sum / 4096;
    mute    = 0;
    if (idx >= size && !loopena) begin
      newoff = w0; mute = 1;
    end else if (sidx >= size && loopena) begin
      newoff = ((sidx + 1048576 - looplen) % 1048576) * 4096 + (sum % 4096);
    end else if (sidx >= size) begin
      newoff = size * 4096; mute = 1; exp_done.push_back(c);
    end else begin
      newoff = sum % 64'h1_0000_0000;
    end
    nw = newoff[31:0];
    wa = 4'(c * 4);
    mram[c*4] = nw;
    exp_wr.push_back({wa, nw});
    addr = (base + newoff / 4096) % 4194304;
    vl = mute ? 0 : (w1 / 64) % 64;
    vr = mute ? 0 : ((w1 % 64) ^ (surr ? 63 : 0));
    exp_byte.push_back({1'b1, 8'(addr / 65536)});
    exp_byte.push_back({1'b1, 8'((addr / 256) % 256)});
    exp_byte.push_back({1'b1, 8'(addr % 256)});
    exp_byte.push_back({1'b0, 8'((newoff / 16) % 256)});
    exp_byte.push_back({1'b0, 8'(vl)});
    exp_byte.push_back({1'b0, 8'(vr)});
  endtask

  task automatic set_ch(input int c, input logic [31:0] w0, w1, w2, w3);
    ram[c*4] = w0;   ram[c*4+1] = w1;  ram[c*4+2] = w2;  ram[c*4+3] = w3;
    mram[c*4] = w0;  mram[c*4+1] = w1; mram[c*4+2] = w2; mram[c*4+3] = w3;
  endtask

  task automatic rand_ch(input int c);
    logic [19:0] size, idx, ll;
    logic [11:0] frac;
    logic [17:0] step;
    logic [7:0]  blo, vlr;
    logic [5:0]  bhi, vl, vr;
    logic [3:0]  junk;
    logic        le, su;
    size = 20'($urandom_range(1, 'h300));
    idx  = 20'($urandom_range(0, 32'(size) + 3));
    ll   = 20'($urandom_range(0, 32'(size)));
    frac = 12'($urandom);
    step = ($urandom_range(0, 3) == 0) ? 18'($urandom) : 18'($urandom_range(0, 'h8000));
    blo  = 8'($urandom); vlr = 8'($urandom);
    bhi  = 6'($urandom); vl = 6'($urandom); vr = 6'($urandom);
    junk = 4'($urandom);
    le   = 1'($urandom); su = 1'($urandom);
    set_ch(c, {idx, frac}, {step, le, su, vl, vr}, {junk, size, blo}, {junk, ll, vlr[7:6], bhi});
  endtask

  // mode: 0 plain, 1 ten-cycle stall mid-EMIT, 2 random out_rdy, 3 sync while busy,
  //       4 ena dropped during ch0, 5 sync with ovr_clr while busy
  task automatic run_frame(input logic [NCH-1:0] en, input int mode, input int exp_cyc);
    int n;
    for (int c = 0; c < NCH; c++)
      if (en[c] && (mode != 4 || c == 0)) model_ch(c);
    enas = en;
    frame_done = 0;
    @(negedge clk); sync = 1'b1;
    @(negedge clk); sync = 1'b0;
    n = 0;
    fork
      begin
        while (busy && n < 3000) begin n++; @(negedge clk); end
        frame_done = 1;
      end
      begin
        case (mode)
          1: begin
            int k, stalls;
            k = 0;
            while (!bus.out_stb_addr && k < 400) begin @(negedge clk); k++; end
            if (k >= 400) unexpected("stall_no_emit", k);
            else begin
              bus.out_rdy = 1'b0;
              stalls = 0;
              repeat (10) begin
                @(negedge clk);
                if (bus.out_stb_addr || bus.out_stb_mix) stalls++;
              end
              bus.out_rdy = 1'b1;
              check("stall_quiet", stalls, 0);
            end
          end
          2: begin
            while (!frame_done) begin bus.out_rdy = 1'($urandom); @(negedge clk); end
            bus.out_rdy = 1'b1;
          end
          3: begin repeat (5) @(negedge clk); sync = 1'b1; @(negedge clk); sync = 1'b0; end
          4: begin repeat (3) @(negedge clk); ena = 1'b0; end
          5: begin
            repeat (5) @(negedge clk); sync = 1'b1; ovr_clr = 1'b1;
            @(negedge clk); sync = 1'b0; ovr_clr = 1'b0;
          end
          default: ;
        endcase
      end
    join
    if (n >= 3000) unexpected("frame_timeout", n);
    else if (exp_cyc > 0) check("frame_cycles", n, exp_cyc);
    ena = 1'b1;
    repeat (3) @(negedge clk);
    check("wr_left", exp_wr.size(), 0);
    check("bytes_left", exp_byte.size(), 0);
    check("done_left", exp_done.size(), 0);
    exp_wr.delete(); exp_byte.delete(); exp_done.delete();
  endtask

  function automatic int cyc(input logic [NCH-1:0] en);
    return 13 * $countones(en) + 2 * (NCH - $countones(en)) + 1;
  endfunction

  initial begin
    bus.out_rdy = 1'b1;
    for (int i = 0; i < 16; i++) begin ram[i] = '0; mram[i] = '0; end
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_wr_stb", bus.wr_stb, 0);
    check("rst_stb_addr", bus.out_stb_addr, 0);
    check("rst_stb_mix", bus.out_stb_mix, 0);
    check("rst_ch_done", ch_done, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_rd_addr", bus.rd_addr, 0);
    check("rst_wr_addr", bus.wr_addr, 0);
    check("rst_wr_data", bus.wr_data, 0);
    rst_n = 1'b1;
    ena = 1'b1;
    repeat (2) @(negedge clk);

    set_ch(0, 32'h0000_1800, {18'h02000, 1'b0, 1'b0, 6'h20, 6'h10}, {4'h0, 20'h00100, 8'h23}, 32'h0000_0001);
    run_frame(4'b0001, 0, cyc(4'b0001));
    check("basic_ram", ram[0], 32'h0000_3800);

    set_ch(0, 32'h000F_FF00, {18'h00200, 1'b1, 1'b0, 6'h20, 6'h10}, {4'h0, 20'h00100, 8'h00}, {4'h0, 20'h00040, 8'h00});
    run_frame(4'b0001, 0, cyc(4'b0001));
    check("loop_ram", ram[0], 32'h000C_0100);

    set_ch(0, 32'h000F_FF00, {18'h00200, 1'b0, 1'b0, 6'h20, 6'h10}, {4'h0, 20'h00100, 8'h00}, {4'h0, 20'h00040, 8'h00});
    run_frame(4'b0001, 0, cyc(4'b0001));
    check("oneshot_ram", ram[0], 32'h0010_0000);
    run_frame(4'b0001, 0, cyc(4'b0001));
    check("oneshot_idle_ram", ram[0], 32'h0010_0000);

    set_ch(0, 32'h0000_1800, {18'h02000, 1'b0, 1'b0, 6'h20, 6'h10}, {4'h0, 20'h00100, 8'h23}, 32'h0000_0001);
    run_frame(4'b0001, 1, cyc(4'b0001) + 10);

    for (int c = 0; c < NCH; c++) rand_ch(c);
    run_frame(4'b1010, 0, cyc(4'b1010));
    check("disabled_ch0_ram", ram[0], mram[0]);

    run_frame(4'b1111, 3, cyc(4'b1111));
    check("overrun_set", overrun, 1);
    run_frame(4'b0101, 0, cyc(4'b0101));
    check("overrun_sticky", overrun, 1);
    @(negedge clk); ovr_clr = 1'b1;
    @(negedge clk); ovr_clr = 1'b0;
    check("overrun_clr", overrun, 0);
    run_frame(4'b0011, 5, cyc(4'b0011));
    check("overrun_clr_prio", overrun, 0);

    run_frame(4'b1111, 4, 14);

    for (int f = 0; f < 24; f++) begin
      logic [NCH-1:0] en;
      for (int c = 0; c < NCH; c++) if ($urandom_range(0, 1) == 1) rand_ch(c);
      en = 4'($urandom);
      if (f % 2 == 1) run_frame(en, 2, -1);
      else            run_frame(en, 0, cyc(en));
    end

    enas = 4'b1111;
    @(negedge clk); sync = 1'b1;
    @(negedge clk); sync = 1'b0;
    repeat (3) @(negedge clk);
    #5 rst_n = 1'b0;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_wr_stb", bus.wr_stb, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("post_rst_idle", busy, 0);
    check("post_rst_ram", ram[0], mram[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
`default_nettype wire
